// File: rtl/mod_select_pkg.sv
// Shared types and constants for the sequential modulo-select datapath.
// Imported by the remainder unit and the top-level FSM.
package mod_select_pkg;

  localparam int WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mod_select_seq_remainder_unit.sv
// Restoring shift-subtract remainder, one dividend bit per step.
// After WIDTH steps rem holds a % c (or a itself when c is zero).
module remainder_unit
  import mod_select_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] c,
  output logic             last,
  output logic [WIDTH-1:0] rem_out
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH:0]   dsr_x;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;

  // Extra top bit keeps the compare exact for divisors >= 2^(WIDTH-1)
  assign rem_sh = {rem[WIDTH-1:0], dvd[WIDTH-1]};
  assign dsr_x  = {1'b0, dsr};
  assign rem_nx = (rem_sh >= dsr_x) ? (rem_sh - dsr_x) : rem_sh;

  assign last    = (cnt == CW'(WIDTH - 1));
  assign rem_out = rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem <= '0;
      dvd <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= '0;
      dvd <= a;
      dsr <= c;
      cnt <= '0;
    end else if (step) begin
      rem <= rem_nx;
      dvd <= {dvd[WIDTH-2:0], 1'b0};
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mod_select_seq.sv
// z = ((a % c) == zero) ? a-1 : c+1, computed over WIDTH+2 clocks.
// Start/busy/done handshake; results held until the next op completes.
module mod_select_seq
  import mod_select_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             dz
);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] zr;
  logic             cz;
  logic [WIDTH-1:0] g;
  logic             load;
  logic             step;
  logic             last;

  assign load = (state == IDLE) && start;
  assign step = (state == DIV);

  remainder_unit #(
    .WIDTH (WIDTH)
  ) u_rem (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .a       (a),
    .c       (c),
    .last    (last),
    .rem_out (g)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (last) state_nx = CMP;
      end
      CMP: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Both candidates are prepared at acceptance so CMP is a pure select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e  <= '0;
      f  <= '0;
      zr <= '0;
      cz <= 1'b0;
    end else if (load) begin
      e  <= a - WIDTH'(1);
      f  <= c + WIDTH'(1);
      zr <= zero;
      cz <= (c == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z  <= '0;
      dz <= 1'b0;
    end else if (state == CMP) begin
      z  <= (g == zr) ? e : f;
      dz <= cz;
    end
  end

endmodule

// File: tb/tb_mod_select_seq.sv
// Directed-vector bench for mod_select_seq at WIDTH=64.
// Each scenario task drives stimulus and checks its own expectations.
module tb_mod_select_seq;

  localparam int W = 64;
  localparam int LAT = W + 2;
  localparam int PER = W + 3;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] c;
  logic [W-1:0] zero;
  logic         busy;
  logic         done;
  logic [W-1:0] z;
  logic         dz;

  int tests;
  int fails;

  mod_select_seq #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .c     (c),
    .zero  (zero),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one op from IDLE; lat counts edges from the start cycle to done.
  task automatic run_op(
    input  logic [W-1:0] ia,
    input  logic [W-1:0] ic,
    input  logic [W-1:0] iz,
    output int           lat,
    output logic         to,
    output logic         b1
  );
    a     = ia;
    c     = ic;
    zero  = iz;
    start = 1'b1;
    lat   = 0;
    to    = 1'b1;
    b1    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (lat == 1) b1 = busy;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    c     = '0;
    zero  = '0;
    #3;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
    end
    tests++;
    if (z !== '0 || dz !== 1'b0) begin
      fails++;
      $display("FAIL reset_z z=%0d dz=%b want 0 0", z, dz);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int   lat;
    logic to;
    logic b1;
    run_op(64'd256, 64'd15, 64'd0, lat, to, b1);
    tests++;
    if (to !== 1'b0 || lat != LAT) begin
      fails++;
      $display("FAIL basic_lat lat=%0d to=%b want %0d", lat, to, LAT);
    end
    tests++;
    if (b1 !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy busy=%b want 1", b1);
    end
    tests++;
    if (z !== 64'd16 || dz !== 1'b0) begin
      fails++;
      $display("FAIL basic_z z=%0d dz=%b want 16 0", z, dz);
    end
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || z !== 64'd16) begin
      fails++;
      $display("FAIL basic_after done=%b busy=%b z=%0d want 0 0 16",
               done, busy, z);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] va [3];
    logic [W-1:0] vc [3];
    logic [W-1:0] vz [3];
    logic [W-1:0] ex [3];
    int   lat;
    logic to;
    logic b1;
    va = '{64'd256, 64'd100, 64'd117};
    vc = '{64'd16,  64'd20,  64'd20};
    vz = '{64'd0,   64'd17,  64'd17};
    ex = '{64'd255, 64'd21,  64'd116};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vc[i], vz[i], lat, to, b1);
      tests++;
      if (to !== 1'b0 || lat != LAT || z !== ex[i] || dz !== 1'b0) begin
        fails++;
        $display("FAIL b2b_%0d lat=%0d z=%0d dz=%b want %0d %0d 0",
                 i, lat, z, dz, LAT, ex[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignore_start;
    int   lat;
    int   extra;
    logic seen;
    a     = 64'd256;
    c     = 64'd15;
    zero  = 64'd0;
    start = 1'b1;
    lat   = 0;
    seen  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        a    = 64'd117;
        c    = 64'd20;
        zero = 64'd17;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    tests++;
    if (!seen || lat != LAT || z !== 64'd16) begin
      fails++;
      $display("FAIL ignore_first seen=%b lat=%0d z=%0d want 1 %0d 16",
               seen, lat, z, LAT);
    end
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    tests++;
    if (extra != 0 || busy !== 1'b0 || z !== 64'd16) begin
      fails++;
      $display("FAIL ignore_extra dones=%0d busy=%b z=%0d want 0 0 16",
               extra, busy, z);
    end
  endtask

  task automatic test_wrap;
    int   lat;
    logic to;
    logic b1;
    run_op(64'd0, 64'd0, 64'd0, lat, to, b1);
    tests++;
    if (to !== 1'b0 || z !== {W{1'b1}} || dz !== 1'b1) begin
      fails++;
      $display("FAIL wrap_czero z=%h dz=%b want all-ones 1", z, dz);
    end
    @(posedge clk);
    #1;
    run_op(64'd5, {W{1'b1}}, 64'd5, lat, to, b1);
    tests++;
    if (to !== 1'b0 || z !== 64'd4 || dz !== 1'b0) begin
      fails++;
      $display("FAIL wrap_cmax z=%0d dz=%b want 4 0", z, dz);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort;
    int   lat;
    int   nd;
    logic to;
    logic b1;
    a     = 64'd256;
    c     = 64'd16;
    zero  = 64'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== '0 || dz !== 1'b0) begin
      fails++;
      $display("FAIL abort_rst busy=%b done=%b z=%0d dz=%b want 0 0 0 0",
               busy, done, z, dz);
    end
    @(negedge clk);
    rst = 1'b1;
    nd  = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    tests++;
    if (nd != 0 || z !== '0) begin
      fails++;
      $display("FAIL abort_nodone dones=%0d z=%0d want 0 0", nd, z);
    end
    run_op(64'd117, 64'd20, 64'd17, lat, to, b1);
    tests++;
    if (to !== 1'b0 || lat != LAT || z !== 64'd116) begin
      fails++;
      $display("FAIL abort_next lat=%0d z=%0d want %0d 116", lat, z, LAT);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_held_start;
    int   de [$];
    int   zbad;
    logic early;
    a     = 64'd256;
    c     = 64'd15;
    zero  = 64'd0;
    start = 1'b1;
    zbad  = 0;
    early = 1'b0;
    for (int i = 1; i <= LAT + 2 * PER; i++) begin
      @(posedge clk);
      #1;
      if (de.size() == 0 && !done && z !== 64'd116) early = 1'b1;
      if (done) begin
        de.push_back(i);
        if (z !== 64'd16) zbad++;
      end
    end
    start = 1'b0;
    tests++;
    if (de.size() != 3) begin
      fails++;
      $display("FAIL held_count dones=%0d want 3", de.size());
    end else begin
      tests++;
      if (de[0] != LAT || de[1] - de[0] != PER || de[2] - de[1] != PER) begin
        fails++;
        $display("FAIL held_spacing at %0d %0d %0d want %0d %0d %0d",
                 de[0], de[1], de[2], LAT, LAT + PER, LAT + 2 * PER);
      end
    end
    tests++;
    if (early || zbad != 0) begin
      fails++;
      $display("FAIL held_z early_change=%b bad_z=%0d want 0 0", early, zbad);
    end
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL held_idle busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_ignore_start;
    test_wrap;
    test_abort;
    test_held_start;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
